// File: rtl/mem_port_master.sv
// mem_port_master
// Turns byte/half/word load and store requests into accesses on a single-port,
// 32-bit-wide word RAM. The RAM has a one-cycle read latency.
// Sub-word stores are done as a read-modify-write. Requests that are
// misaligned, use an illegal size, or fall outside the RAM get an error
// response and never touch the RAM.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             request channel (valid/ready handshake, captured on accept)
//   rsp_*             response channel (one-cycle valid pulse, data/err held)
//   mem_*             word RAM port (mem_dout valid one cycle after a read)
module mem_port_master #(
    parameter int index_width = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    // Holds the store data at accept time. For sub-word stores it is
    // overwritten with the merged word before WR.
    logic [31:0] r_data;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_outOfRange;
    logic        w_reqErr;
    logic [4:0]  w_shift;
    logic [31:0] w_laneMask;
    logic [31:0] w_lane;
    logic [31:0] w_loadData;
    logic [31:0] w_merged;

    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_outOfRange = (req_addr >> (index_width + 2)) != 32'd0;

    // Classify the incoming request. Any error sends it straight to RESP.
    always_comb begin
        w_reqErr = 1'b0;
        case (req_size)
            2'b00:   w_reqErr = w_outOfRange;
            2'b01:   w_reqErr = req_addr[0] || w_outOfRange;
            2'b10:   w_reqErr = (req_addr[1:0] != 2'b00) || w_outOfRange;
            default: w_reqErr = 1'b1;
        endcase
    end

    // Lane position and width for the captured request.
    // Loads extract this lane. Sub-word stores splice it into the read word.
    always_comb begin
        w_shift    = 5'd0;
        w_laneMask = 32'hFFFF_FFFF;
        case (r_size)
            2'b00: begin
                w_shift    = {r_addr[1:0], 3'b000};
                w_laneMask = 32'h0000_00FF;
            end
            2'b01: begin
                w_shift    = {r_addr[1], 4'b0000};
                w_laneMask = 32'h0000_FFFF;
            end
            default: begin
                w_shift    = 5'd0;
                w_laneMask = 32'hFFFF_FFFF;
            end
        endcase
        w_lane     = (mem_dout >> w_shift) & w_laneMask;
        w_loadData = w_lane;
        if (!r_unsigned) begin
            case (r_size)
                2'b00:   w_loadData = {{24{w_lane[7]}}, w_lane[7:0]};
                2'b01:   w_loadData = {{16{w_lane[15]}}, w_lane[15:0]};
                default: w_loadData = w_lane;
            endcase
        end
        w_merged = (mem_dout & ~(w_laneMask << w_shift)) | ((r_data & w_laneMask) << w_shift);
    end

    // Next-state logic.
    // A word store skips the read. A sub-word store takes the read path
    // first and then branches to WR.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_reqErr)                w_nextState = RESP;
                    else if (!req_we)            w_nextState = RD;
                    else if (req_size == 2'b10)  w_nextState = WR;
                    else                         w_nextState = RD;
                end
            end
            RD:      w_nextState = RD_WAIT;
            RD_WAIT: w_nextState = r_we ? WR : RESP;
            WR:      w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State register, captured request, and held response.
    // The response registers change only on the edge that enters RESP.
    // Reset discards any half-finished transaction, including a pending
    // read-modify-write write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_data     <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_we       <= req_we;
                r_addr     <= req_addr;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_data     <= req_wdata;
                if (w_reqErr) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end
            end
            if (r_state == RD_WAIT) begin
                if (r_we) begin
                    r_data <= w_merged;
                end else begin
                    r_rdata <= w_loadData;
                    r_err   <= 1'b0;
                end
            end
            if (r_state == WR) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign mem_en    = (r_state == RD) || (r_state == WR);
    assign mem_we    = (r_state == WR);
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_din   = r_data;

endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master
// Drives mem_port_master against a behavioural word RAM.
// Responses are checked against a shadow copy of memory. The shadow copy is
// updated by plain arithmetic lane rules.
module tb_mem_port_master;

    localparam int IW  = 10;
    localparam int WIN = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int tests = 0;
    int fails = 0;

    logic [31:0] ram [0:1023];
    logic [31:0] shadow [0:WIN-1];
    logic        preload;
    int          preIdx;
    logic [31:0] preVal;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        bit          expErr;
        int          expLat;
    } dirOp_t;

    always #5 clk = ~clk;

    mem_port_master #(.index_width(IW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // Word RAM: read data appears one cycle after the read is sampled.
    always @(posedge clk) begin
        if (preload) begin
            ram[preIdx] <= preVal;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[11:2]] <= mem_din;
            else        mem_dout <= ram[mem_addr[11:2]];
        end
    end

    // Reference model: expected result of one access, updating the shadow on stores.
    task automatic refAccess(input bit we, input logic [31:0] addr, input logic [1:0] size,
                             input bit uns, input logic [31:0] wdata,
                             output logic [31:0] rdata, output bit err, output int lat);
        logic [31:0] word;
        logic [31:0] lane;
        logic [31:0] bits;
        int sh;
        int idx;
        err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || (addr >= (32'd4 << IW));
        rdata = 32'd0;
        lat   = 1;
        if (!err) begin
            idx  = int'(addr / 4);
            word = shadow[idx];
            if (size == 2'd2) begin
                sh = 0;  bits = 32'hFFFF_FFFF;
            end else if (size == 2'd1) begin
                sh = 16 * int'((addr % 4) / 2);  bits = 32'hFFFF;
            end else begin
                sh = 8 * int'(addr % 4);  bits = 32'hFF;
            end
            lane = (word >> sh) & bits;
            if (!we) begin
                lat = 3;
                if (size == 2'd2)      rdata = word;
                else if (uns)          rdata = lane;
                else if (size == 2'd1) rdata = (lane ^ 32'h8000) - 32'h8000;
                else                   rdata = (lane ^ 32'h80) - 32'h80;
            end else begin
                lat = (size == 2'd2) ? 2 : 4;
                shadow[idx] = word - (lane << sh) + ((wdata & bits) << sh);
            end
        end
    endtask

    // Issue one request and report what the DUT did.
    // Latency is the number of cycles after the accepting edge up to and
    // including the RESP cycle.
    task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [1:0] size,
                                 input bit uns, input logic [31:0] wdata,
                                 output int lat, output logic [31:0] rdata, output logic err,
                                 output bit memEnSeen, output logic validAfter,
                                 output logic [31:0] rdataAfter, output logic errAfter);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, guard);
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_addr     = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
        lat       = 0;
        memEnSeen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_en) memEnSeen = 1'b1;
        end while (!rsp_valid && lat < 12);
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
        validAfter = rsp_valid;
        rdataAfter = rsp_rdata;
        errAfter   = rsp_err;
    endtask

    task automatic test_reset();
        req_valid = 1'b0;  req_we = 1'b0;  req_addr = 32'd0;  req_size = 2'd0;
        req_unsigned = 1'b0;  req_wdata = 32'd0;
        rst_n = 1'b0;
        preload = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            preIdx = i;
            preVal = $urandom;
            shadow[i] = preVal;
        end
        @(negedge clk);
        preload = 1'b0;
        tests++;
        if ({mem_en, mem_we, rsp_valid, rsp_err} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: {en,we,valid,err}=%b required 0000", {mem_en, mem_we, rsp_valid, rsp_err});
        end
        tests++;
        if (rsp_rdata !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset_rdata: got %h required 00000000", rsp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_release: ready=%b valid=%b required ready=1 valid=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_directed();
        dirOp_t ops [9];
        int lat;  logic [31:0] rd;  logic er;  bit en;  logic va;  logic [31:0] rda;  logic era;
        logic [31:0] mRd;  bit mEr;  int mLat;
        ops[0] = '{1'b1, 32'h10,   2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 2};
        ops[1] = '{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        ops[2] = '{1'b1, 32'h11,   2'd0, 1'b0, 32'h55,       32'h0,        1'b0, 4};
        ops[3] = '{1'b0, 32'h13,   2'd0, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0, 3};
        ops[4] = '{1'b0, 32'h13,   2'd0, 1'b1, 32'h0,        32'h000000DE, 1'b0, 3};
        ops[5] = '{1'b0, 32'h12,   2'd1, 1'b0, 32'h0,        32'hFFFFDEAD, 1'b0, 3};
        ops[6] = '{1'b0, 32'h11,   2'd1, 1'b0, 32'h0,        32'h0,        1'b1, 1};
        ops[7] = '{1'b0, 32'h1000, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1, 1};
        ops[8] = '{1'b0, 32'h10,   2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 1};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(ops[i].we, ops[i].addr, ops[i].size, ops[i].uns, ops[i].wdata,
                          lat, rd, er, en, va, rda, era);
            refAccess(ops[i].we, ops[i].addr, ops[i].size, ops[i].uns, ops[i].wdata, mRd, mEr, mLat);
            tests++;
            if (rd !== ops[i].expRdata || er !== ops[i].expErr) begin
                fails++;
                $display("[TB] FAIL dir%0d_rsp: rdata=%h err=%b required rdata=%h err=%b",
                         i, rd, er, ops[i].expRdata, ops[i].expErr);
            end
            tests++;
            if (lat != ops[i].expLat) begin
                fails++;
                $display("[TB] FAIL dir%0d_latency: got %0d required %0d", i, lat, ops[i].expLat);
            end
            if (ops[i].expErr) begin
                tests++;
                if (en !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL dir%0d_no_mem: mem_en seen=%b required 0", i, en);
                end
            end
            if (i == 2) begin
                tests++;
                if (ram[4] !== 32'hDEAD55EF) begin
                    fails++;
                    $display("[TB] FAIL dir_rmw_word: ram=%h required DEAD55EF", ram[4]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;  logic [31:0] expRd;  logic [31:0] gotRd;  bit mEr;  int mLat;
        int firstReady;  int resp0;  int resp1;
        wd = $urandom;
        refAccess(1'b1, 32'h21, 2'd0, 1'b0, wd, expRd, mEr, mLat);
        refAccess(1'b0, 32'h20, 2'd2, 1'b0, 32'd0, expRd, mEr, mLat);
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;  req_we = 1'b1;  req_addr = 32'h21;  req_size = 2'd0;
        req_unsigned = 1'b0;  req_wdata = wd;
        @(posedge clk);
        #1;
        req_we = 1'b0;  req_addr = 32'h20;  req_size = 2'd2;  req_wdata = $urandom;
        firstReady = 0;  resp0 = -1;  resp1 = -1;  gotRd = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (resp0 < 0) resp0 = k;
                else if (resp1 < 0) begin
                    resp1 = k;
                    gotRd = rsp_rdata;
                end
            end
            if (req_ready && firstReady == 0) begin
                firstReady = k;
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        tests++;
        if (resp0 != 4) begin
            fails++;
            $display("[TB] FAIL b2b_rmw_resp: cycle %0d required 4", resp0);
        end
        tests++;
        if (firstReady != 5) begin
            fails++;
            $display("[TB] FAIL b2b_accept: ready first in cycle %0d required 5", firstReady);
        end
        tests++;
        if (resp1 != 8) begin
            fails++;
            $display("[TB] FAIL b2b_load_resp: cycle %0d required 8", resp1);
        end
        tests++;
        if (gotRd !== expRd) begin
            fails++;
            $display("[TB] FAIL b2b_load_data: got %h required %h", gotRd, expRd);
        end
    endtask

    task automatic test_random();
        bit we;  bit uns;  logic [1:0] size;  logic [31:0] addr;  logic [31:0] wd;  int sel;
        int lat;  logic [31:0] rd;  logic er;  bit en;  logic va;  logic [31:0] rda;  logic era;
        logic [31:0] mRd;  bit mEr;  int mLat;
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            sel  = int'($urandom_range(0, 9));
            size = (sel == 0) ? 2'd3 : 2'(sel % 3);
            wd   = $urandom;
            addr = $urandom_range(0, WIN * 4 - 1);
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd2)      addr = addr & ~32'd3;
                else if (size == 2'd1) addr = addr & ~32'd1;
            end
            if ($urandom_range(0, 9) == 0) addr = addr | (32'd1 << $urandom_range(12, 31));
            refAccess(we, addr, size, uns, wd, mRd, mEr, mLat);
            applyStimulus(we, addr, size, uns, wd, lat, rd, er, en, va, rda, era);
            tests++;
            if (rd !== mRd || er !== mEr || lat != mLat) begin
                fails++;
                $display("[TB] FAIL rnd%0d_rsp: we=%b addr=%h size=%0d rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=%0d",
                         n, we, addr, size, rd, er, lat, mRd, mEr, mLat);
            end
            tests++;
            if (va !== 1'b0 || rda !== mRd || era !== mEr) begin
                fails++;
                $display("[TB] FAIL rnd%0d_hold: valid=%b rdata=%h err=%b required valid=0 rdata=%h err=%b",
                         n, va, rda, era, mRd, mEr);
            end
            if (mEr) begin
                tests++;
                if (en !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL rnd%0d_no_mem: mem_en seen=%b required 0", n, en);
                end
            end else if (we) begin
                tests++;
                if (ram[addr[11:2]] !== shadow[addr[7:2]]) begin
                    fails++;
                    $display("[TB] FAIL rnd%0d_ram: word=%h required %h", n, ram[addr[11:2]], shadow[addr[7:2]]);
                end
            end
        end
    endtask

    task automatic test_reset_midRmw();
        bit seen;
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;  req_we = 1'b1;  req_addr = 32'h15;  req_size = 2'd0;
        req_unsigned = 1'b0;  req_wdata = ~{24'd0, shadow[5][15:8]};
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rst_rmw_read: en=%b we=%b required en=1 we=0", mem_en, mem_we);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({mem_en, mem_we, rsp_valid} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL rst_rmw_async: {en,we,valid}=%b required 000", {mem_en, mem_we, rsp_valid});
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid || mem_en) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rst_rmw_quiet: activity=%b ready=%b required activity=0 ready=1", seen, req_ready);
        end
        tests++;
        if (ram[5] !== shadow[5]) begin
            fails++;
            $display("[TB] FAIL rst_rmw_word: ram=%h required %h", ram[5], shadow[5]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midRmw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
